// File: rtl/vfd_pkg.sv
// Shared constants and types for the MN15439A VFD tri-SPI link.
// Used by the receiver, its grid decoder and the transmitter-side checkers.
package vfd_pkg;

  localparam int NBITS     = 288;
  localparam int NPIX      = 234;
  localparam int NGRID     = 52;
  localparam int NGCP      = 6;
  localparam int GRID_BASE = 234;
  localparam int GRID_W    = NBITS - GRID_BASE;

  localparam logic [8:0] BITCNT_LAST = 9'd287;
  localparam logic [8:0] BITCNT_FULL = 9'd288;
  localparam logic [7:0] PIX_LAST    = 8'd233;

  // Bit offsets within an update at which the transmitter emits GCP; index 0 is the first pulse
  localparam logic [NGCP-1:0][8:0] GCP_OFFS = {9'd256, 9'd240, 9'd216, 9'd192, 9'd144, 9'd72};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/tri_spi_rx_if.sv
// VFD pin bundle between the tri-SPI transmitter (master) and a receiver (slave).
interface tri_spi_rx_if;

  logic       SCK_EN;
  logic [2:0] SIN;
  logic       LAT;
  logic       BLK;
  logic       GCP;

  modport master (output SCK_EN, SIN, LAT, BLK, GCP);
  modport slave  (input  SCK_EN, SIN, LAT, BLK, GCP);

endinterface

// File: rtl/tri_spi_grid_decode.sv
// Grid-select field decoder: valid only for one adjacent pair of ones at field
// bits N-1 and N (1 <= N <= NGRID) identical on all three lanes.
module tri_spi_grid_decode
  import vfd_pkg::*;
(
  input  logic [2:0][GRID_W-1:0] field,
  output logic                   valid,
  output logic [5:0]             num
);

  localparam logic [GRID_W-1:0] PAIR = {{(GRID_W-2){1'b0}}, 2'b11};

  // Match lane-0 pattern against every legal grid position
  always_comb begin
    valid = 1'b0;
    num   = 6'd0;
    if ((field[0] == field[1]) && (field[1] == field[2])) begin
      for (int n = 1; n <= NGRID; n++) begin
        if (field[0] == (PAIR << (n - 1))) begin
          valid = 1'b1;
          num   = 6'(n);
        end
      end
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/tri_spi_rx.sv
// Receive-side model of the MN15439A tri-lane serial interface: deserialises a
// 288-bit update, latches it on LAT, validates grid/length/GCP and serves pixels.
module tri_spi_rx
  import vfd_pkg::*;
(
  input  logic         CLK,
  input  logic         RSTN,
  tri_spi_rx_if.slave  bus,
  input  logic [7:0]   PIX_ADDR,
  output logic [2:0]   PIX_LEVEL,
  output logic [5:0]   GRID_NUM,
  output logic         FRAME_VALID,
  output logic         LEN_ERR,
  output logic         GRID_ERR,
  output logic [2:0]   GCP_CNT,
  output logic         GCP_ERR,
  output logic         DISP_ON
);

  state_t                    state_r;
  logic [8:0]                bitcnt_r;
  logic                      overrun_r;
  logic [NBITS-1:0][2:0]     shift_r;
  logic [NPIX-1:0][2:0]      latch_r;
  logic                      lat_r, lat_prev_r, blk_r, gcp_r, gcp_prev_r;
  logic [5:0]                grid_num_r;
  logic                      frame_valid_r, len_err_r, grid_err_r, gcp_err_r;
  logic                      seen_valid_r, latched_once_r, disp_on_r;
  logic [2:0]                gcp_cnt_r, pix_level_r;
  logic [2:0][GRID_W-1:0]    grid_field_s;
  logic                      dec_valid_s, grid_ok_s, len_bad_s, gcp_bad_s;
  logic                      lat_edge_s, gcp_edge_s;
  logic [5:0]                dec_num_s;

  assign lat_edge_s = lat_r & ~lat_prev_r;
  assign gcp_edge_s = gcp_r & ~gcp_prev_r;
  // A grid field is only trusted when all 288 bits arrived
  assign grid_ok_s  = dec_valid_s & (state_r == FULL);
  assign len_bad_s  = (bitcnt_r != BITCNT_FULL) | overrun_r;
  assign gcp_bad_s  = ~((gcp_cnt_r == 3'd6) | ((gcp_cnt_r == 3'd0) & ~latched_once_r));

  // Regroup the grid bits of the shift store per lane for the decoder
  always_comb begin
    grid_field_s = '0;
    for (int i = 0; i < GRID_W; i++) begin
      for (int l = 0; l < 3; l++) begin
        grid_field_s[l][i] = shift_r[GRID_BASE + i][l];
      end
    end
  end

  tri_spi_grid_decode u_grid_decode (
    .field (grid_field_s),
    .valid (dec_valid_s),
    .num   (dec_num_s)
  );

  // Register stage and edge history for LAT, BLK and GCP
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      lat_r      <= 1'b0;
      lat_prev_r <= 1'b0;
      blk_r      <= 1'b0;
      gcp_r      <= 1'b0;
      gcp_prev_r <= 1'b0;
    end else begin
      lat_r      <= bus.LAT;
      lat_prev_r <= lat_r;
      blk_r      <= bus.BLK;
      gcp_r      <= bus.GCP;
      gcp_prev_r <= gcp_r;
    end
  end

  // Shift FSM; a LAT edge restarts the update and may capture bit 0 in the same cycle
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r   <= IDLE;
      bitcnt_r  <= 9'd0;
      overrun_r <= 1'b0;
      shift_r   <= '0;
    end else if (lat_edge_s) begin
      overrun_r <= 1'b0;
      if (bus.SCK_EN) begin
        shift_r[0] <= bus.SIN;
        bitcnt_r   <= 9'd1;
        state_r    <= SHIFT;
      end else begin
        bitcnt_r <= 9'd0;
        state_r  <= IDLE;
      end
    end else if (bus.SCK_EN) begin
      case (state_r)
        IDLE, SHIFT: begin
          shift_r[bitcnt_r] <= bus.SIN;
          bitcnt_r          <= bitcnt_r + 9'd1;
          state_r           <= (bitcnt_r == BITCNT_LAST) ? FULL : SHIFT;
        end
        FULL:    overrun_r <= 1'b1;
        default: state_r   <= IDLE;
      endcase
    end
  end

  // Latch action: copy pixels, decode grid, accumulate length and grid errors
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      latch_r       <= '0;
      grid_num_r    <= 6'd0;
      frame_valid_r <= 1'b0;
      len_err_r     <= 1'b0;
      grid_err_r    <= 1'b0;
      seen_valid_r  <= 1'b0;
    end else begin
      frame_valid_r <= lat_edge_s;
      if (lat_edge_s) begin
        latch_r    <= shift_r[NPIX-1:0];
        grid_num_r <= grid_ok_s ? dec_num_s : 6'd0;
        if (!grid_ok_s) grid_err_r <= 1'b1;
        if (len_bad_s) len_err_r <= 1'b1;
        if (grid_ok_s && !len_bad_s && !gcp_bad_s) seen_valid_r <= 1'b1;
      end
    end
  end

  // GCP pulse counting; the count at LAT must be NGCP (or 0 before the first latch)
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      gcp_cnt_r      <= 3'd0;
      gcp_err_r      <= 1'b0;
      latched_once_r <= 1'b0;
    end else if (lat_edge_s) begin
      gcp_cnt_r      <= {2'b00, gcp_edge_s};
      latched_once_r <= 1'b1;
      if (gcp_bad_s) gcp_err_r <= 1'b1;
    end else if (gcp_edge_s) begin
      if (gcp_cnt_r != 3'd7) gcp_cnt_r <= gcp_cnt_r + 3'd1;
      if (gcp_cnt_r == 3'd6) gcp_err_r <= 1'b1;
    end
  end

  // Registered pixel read port and display enable
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pix_level_r <= 3'd0;
      disp_on_r   <= 1'b0;
    end else begin
      pix_level_r <= (PIX_ADDR <= PIX_LAST) ? latch_r[PIX_ADDR] : 3'd0;
      disp_on_r   <= ~blk_r & seen_valid_r;
    end
  end

  assign PIX_LEVEL   = pix_level_r;
  assign GRID_NUM    = grid_num_r;
  assign FRAME_VALID = frame_valid_r;
  assign LEN_ERR     = len_err_r;
  assign GRID_ERR    = grid_err_r;
  assign GCP_CNT     = gcp_cnt_r;
  assign GCP_ERR     = gcp_err_r;
  assign DISP_ON     = disp_on_r;

endmodule

// File: tb/tb_tri_spi_rx.sv
// Randomised bench for tri_spi_rx: a bit-level reference model predicts each
// latched update, and a FRAME_VALID monitor checks it against a scoreboard.
`timescale 1ns/1ps
module tb_tri_spi_rx;
  import vfd_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [7:0] PIX_ADDR = 8'd0;
  logic [2:0] PIX_LEVEL;
  logic [5:0] GRID_NUM;
  logic       FRAME_VALID, LEN_ERR, GRID_ERR, GCP_ERR, DISP_ON;
  logic [2:0] GCP_CNT;

  tri_spi_rx_if bus();

  tri_spi_rx dut (
    .CLK(CLK), .RSTN(RSTN), .bus(bus), .PIX_ADDR(PIX_ADDR),
    .PIX_LEVEL(PIX_LEVEL), .GRID_NUM(GRID_NUM), .FRAME_VALID(FRAME_VALID),
    .LEN_ERR(LEN_ERR), .GRID_ERR(GRID_ERR), .GCP_CNT(GCP_CNT),
    .GCP_ERR(GCP_ERR), .DISP_ON(DISP_ON)
  );

  always #42 CLK = ~CLK;

  typedef struct {
    int grid_num;
    bit len_err;
    bit grid_err;
    bit gcp_err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  bit [2:0] m_shift [NBITS];
  bit [2:0] m_latch [NPIX];
  bit [2:0] frame   [NBITS];
  int       m_bits, m_gcp;
  bit       m_once, m_seen, m_len_err, m_grid_err, m_gcp_err, m_blk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NBITS; i++) m_shift[i] = 3'd0;
    for (int i = 0; i < NPIX; i++) m_latch[i] = 3'd0;
    m_bits = 0; m_gcp = 0;
    m_once = 1'b0; m_seen = 1'b0;
    m_len_err = 1'b0; m_grid_err = 1'b0; m_gcp_err = 1'b0;
  endtask

  // Grid N from the stored field: exactly two all-lane positions, adjacent, first at 233+N
  function automatic int model_grid();
    int pos[$];
    for (int p = GRID_BASE; p < NBITS; p++) begin
      if (m_shift[p] != 3'd0) begin
        if (m_shift[p] != 3'b111) return 0;
        pos.push_back(p);
      end
    end
    if (pos.size() != 2) return 0;
    if (pos[1] != pos[0] + 1) return 0;
    if (pos[0] - 233 > NGRID) return 0;
    return pos[0] - 233;
  endfunction

  // kind 0: legal grid n; 1: ones at 240/242; 2: lanes disagree at grid n
  task automatic build_frame(int n, int kind, int pix);
    for (int i = 0; i < NPIX; i++)
      frame[i] = (pix < 0) ? 3'($urandom_range(0, 7)) : 3'(pix);
    for (int i = GRID_BASE; i < NBITS; i++) frame[i] = 3'd0;
    case (kind)
      0: begin frame[233 + n] = 3'b111; frame[234 + n] = 3'b111; end
      1: begin frame[240] = 3'b111; frame[242] = 3'b111; end
      default: begin frame[233 + n] = 3'b111; frame[234 + n] = 3'b011; end
    endcase
  endtask

  task automatic send_bits(int nbits, int npulse);
    bit pulse;
    for (int i = 0; i < nbits; i++) begin
      while ($urandom_range(0, 4) == 0) begin
        bus.SCK_EN = 1'b0; bus.GCP = 1'b0; tick();
      end
      pulse = 1'b0;
      for (int k = 0; k < npulse; k++)
        if (((k < NGCP) ? int'(GCP_OFFS[k]) : 280) == i) pulse = 1'b1;
      bus.SCK_EN = 1'b1;
      bus.SIN    = (i < NBITS) ? frame[i] : 3'($urandom_range(0, 7));
      bus.GCP    = pulse;
      if (m_bits < NBITS) m_shift[m_bits] = bus.SIN;
      m_bits++;
      if (pulse) begin
        m_gcp++;
        if (m_gcp > NGCP) m_gcp_err = 1'b1;
      end
      tick();
    end
    bus.SCK_EN = 1'b0; bus.GCP = 1'b0;
    tick(); tick();
  endtask

  task automatic do_latch();
    exp_t e;
    int   n;
    bit   le, ge, gb;
    le = (m_bits != NBITS);
    n  = (m_bits >= NBITS) ? model_grid() : 0;
    ge = (n == 0);
    gb = !((m_gcp == NGCP) || (m_gcp == 0 && !m_once));
    m_len_err  |= le;
    m_grid_err |= ge;
    m_gcp_err  |= gb;
    if (!le && !ge && !gb) m_seen = 1'b1;
    for (int a = 0; a < NPIX; a++) m_latch[a] = m_shift[a];
    m_once = 1'b1; m_bits = 0; m_gcp = 0;
    e.grid_num = n; e.len_err = m_len_err; e.grid_err = m_grid_err; e.gcp_err = m_gcp_err;
    exp_q.push_back(e);
    bus.LAT = 1'b1; tick();
    bus.LAT = 1'b0; tick(); tick(); tick();
    check("gcp_cnt_after_lat", GCP_CNT, 0);
  endtask

  task automatic check_pix(int addr);
    int exp;
    PIX_ADDR = 8'(addr);
    tick();
    exp = 0;
    if (addr < NPIX) exp = m_latch[addr];
    check("pix_level", PIX_LEVEL, exp);
  endtask

  task automatic check_disp();
    tick(); tick(); tick();
    check("disp_on", DISP_ON, (!m_blk && m_seen) ? 1 : 0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_pix_level"}, PIX_LEVEL, 0);
    check({tag, "_grid_num"}, GRID_NUM, 0);
    check({tag, "_frame_valid"}, FRAME_VALID, 0);
    check({tag, "_len_err"}, LEN_ERR, 0);
    check({tag, "_grid_err"}, GRID_ERR, 0);
    check({tag, "_gcp_cnt"}, GCP_CNT, 0);
    check({tag, "_gcp_err"}, GCP_ERR, 0);
    check({tag, "_disp_on"}, DISP_ON, 0);
  endtask

  task automatic update(int n, int kind, int pix, int nbits, int npulse);
    build_frame(n, kind, pix);
    send_bits(nbits, npulse);
    check("gcp_cnt_pre_lat", GCP_CNT, (m_gcp > 7) ? 7 : m_gcp);
    check("gcp_err_pre_lat", GCP_ERR, m_gcp_err ? 1 : 0);
    do_latch();
    check_pix($urandom_range(0, NPIX - 1));
    check_pix($urandom_range(0, NPIX - 1));
  endtask

  // Scoreboard monitor: every FRAME_VALID pulse consumes one prediction
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RSTN && FRAME_VALID) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_valid: pulse with no update pending at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("grid_num", GRID_NUM, e.grid_num);
        check("len_err", LEN_ERR, e.len_err);
        check("grid_err", GRID_ERR, e.grid_err);
        check("gcp_err", GCP_ERR, e.gcp_err);
      end
    end
  end

  initial begin
    bus.SCK_EN = 1'b0; bus.SIN = 3'd0; bus.LAT = 1'b0; bus.BLK = 1'b0; bus.GCP = 1'b0;
    m_blk = 1'b0;
    model_reset();
    repeat (3) tick();
    check_zero("reset");
    RSTN = 1'b1;
    tick();

    update(5, 0, 5, NBITS, 0);
    check_pix(100); check_pix(0); check_pix(233); check_pix(234); check_pix(255);
    check_disp();
    for (int r = 0; r < 3; r++) update($urandom_range(1, NGRID), 0, -1, NBITS, NGCP);
    update(NGRID, 0, -1, NBITS, NGCP);
    update(1, 0, -1, NBITS, NGCP);

    bus.BLK = 1'b1; m_blk = 1'b1; check_disp();
    bus.BLK = 1'b0; m_blk = 1'b0; check_disp();

    update($urandom_range(1, NGRID), 0, -1, NBITS, 7);

    // Reset in the middle of an update
    build_frame(9, 0, -1);
    send_bits(150, 2);
    RSTN = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    tick(); tick();
    RSTN = 1'b1;
    tick();
    update($urandom_range(1, NGRID), 0, -1, NBITS, 0);
    check_disp();
    update($urandom_range(1, NGRID), 0, -1, NBITS, NGCP);
    update($urandom_range(1, NGRID), 0, -1, NBITS, 5);
    update(0, 1, -1, NBITS, NGCP);
    update($urandom_range(1, NGRID), 2, -1, NBITS, NGCP);
    update($urandom_range(1, NGRID), 0, -1, NBITS - 1, NGCP);
    update($urandom_range(1, NGRID), 0, -1, NBITS, NGCP);
    update($urandom_range(1, NGRID), 0, -1, NBITS + 2, NGCP);
    do_latch();
    check_disp();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d updates never reported, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
